// File: rtl/miss_counter_pkg.sv
// Shared definitions for the branch-misprediction statistics counter.
package miss_counter_pkg;

  // Default counter width used when the top is instantiated without overrides.
  localparam int MISS_CNT_WIDTH = 16;

  // Widest counter the all-ones helper can describe.
  localparam int MISS_CNT_MAX_WIDTH = 32;

  // All-ones value for a counter of the given width, zero-extended to 32 bits.
  function automatic logic [MISS_CNT_MAX_WIDTH-1:0] all_ones(input int width);
    if (width >= MISS_CNT_MAX_WIDTH) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/miss_counter_if.sv
// Miss strobe and statistics readout between the branch predictor and the counter.
interface miss_counter_if
  import miss_counter_pkg::*;
#(
  parameter int WIDTH = MISS_CNT_WIDTH
);

  logic             MISS;
  logic [WIDTH-1:0] MISSES;
  logic             SATURATED;

  // Predictor / tooling side: raises misses, reads the statistics.
  modport master (
    output MISS,
    input  MISSES,
    input  SATURATED
  );

  // Counter side: samples misses, publishes the statistics.
  modport slave (
    input  MISS,
    output MISSES,
    output SATURATED
  );

endinterface

// File: rtl/miss_counter_sat_incr.sv
// Combinational saturating incrementer: adds one when enabled, never wraps past all-ones.
module sat_incr #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] next,
  output logic             at_max
);

  logic [WIDTH:0] sum;

  // The carry out of value+1 is set exactly when value is all-ones.
  assign sum    = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
  assign at_max = sum[WIDTH];

  // Hold the value when disabled or already at the ceiling.
  assign next = (en && !at_max) ? sum[WIDTH-1:0] : value;

endmodule

// File: rtl/miss_counter.sv
// Branch-misprediction statistics counter: counts cycles with MISS high, saturating,
// with a sticky flag once the count reaches all-ones.
module miss_counter
  import miss_counter_pkg::*;
#(
  parameter int WIDTH = MISS_CNT_WIDTH
) (
  input  logic         CLOCK,
  input  logic         INIT,
  miss_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] misses_q;
  logic             saturated_q;
  logic [WIDTH-1:0] next_count;
  logic             at_max;
  logic             miss_valid;

  // An unknown or floating strobe counts as no miss so the total never goes X.
  assign miss_valid = (bus.MISS === 1'b1);

  sat_incr #(
    .WIDTH(WIDTH)
  ) u_sat_incr (
    .value  (misses_q),
    .en     (miss_valid),
    .next   (next_count),
    .at_max (at_max)
  );

  // Count register and sticky flag; INIT wins over MISS on the same edge.
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      misses_q    <= '0;
      saturated_q <= 1'b0;
    end else begin
      misses_q    <= next_count;
      saturated_q <= saturated_q | at_max | (next_count == MAX_COUNT);
    end
  end

  assign bus.MISSES    = misses_q;
  assign bus.SATURATED = saturated_q;

endmodule

// File: tb/tb_miss_counter.sv
// Self-checking bench for miss_counter: directed test-plan sequences plus random
// stimulus, run on a 16-bit and a 4-bit instance against a behavioural model.
module tb_miss_counter;
  import miss_counter_pkg::*;

  logic CLOCK = 1'b0;
  logic INIT  = 1'b1;

  miss_counter_if #(.WIDTH(16)) bus16 ();
  miss_counter_if #(.WIDTH(4))  bus4 ();

  miss_counter #(.WIDTH(16)) dut16 (
    .CLOCK (CLOCK),
    .INIT  (INIT),
    .bus   (bus16.slave)
  );

  miss_counter #(.WIDTH(4)) dut4 (
    .CLOCK (CLOCK),
    .INIT  (INIT),
    .bus   (bus4.slave)
  );

  // 10 ns clock.
  always #5 CLOCK = ~CLOCK;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model: plain integer counts clipped at 2^W - 1.
  int modelCount16 = 0;
  int modelCount4  = 0;
  bit modelSat16   = 1'b0;
  bit modelSat4    = 1'b0;
  bit modelValid   = 1'b0;

  localparam int MAX16 = (1 << 16) - 1;
  localparam int MAX4  = (1 << 4) - 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_misses16"}, 32'(bus16.MISSES),    32'(modelCount16));
    checkOutput({tag, "_sat16"},    32'(bus16.SATURATED), 32'(modelSat16));
    checkOutput({tag, "_misses4"},  32'(bus4.MISSES),     32'(modelCount4));
    checkOutput({tag, "_sat4"},     32'(bus4.SATURATED),  32'(modelSat4));
  endtask

  // Drive one edge worth of inputs, check nothing moved before the edge,
  // advance the model at the edge and check the registered result after it.
  task automatic applyStimulus(input string tag, input logic initVal, input logic missVal);
    @(negedge CLOCK);
    INIT      = initVal;
    bus16.MISS = missVal;
    bus4.MISS  = missVal;
    #1;
    if (modelValid) compareAll({tag, "_pre"});
    @(posedge CLOCK);
    if (initVal) begin
      modelCount16 = 0;
      modelCount4  = 0;
      modelSat16   = 1'b0;
      modelSat4    = 1'b0;
      modelValid   = 1'b1;
    end else if (missVal === 1'b1) begin
      if (modelCount16 < MAX16) modelCount16++;
      if (modelCount4 < MAX4)   modelCount4++;
      if (modelCount16 == MAX16) modelSat16 = 1'b1;
      if (modelCount4 == MAX4)   modelSat4  = 1'b1;
    end
    #1;
    if (modelValid) compareAll({tag, "_post"});
  endtask

  // Guard against an unexpected stall of the stimulus thread.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] pattern;
    pattern = 7'b0110100;
    bus16.MISS = 1'b0;
    bus4.MISS  = 1'b0;

    // Reset, then two idle edges.
    applyStimulus("reset", 1'b1, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0);

    // Count pattern 0,0,1,0,1,1,0 (LSB first).
    for (int i = 0; i < 7; i++) applyStimulus("pattern", 1'b0, pattern[i]);

    // Reach 5, then INIT and MISS together, then one miss.
    applyStimulus("to5", 1'b0, 1'b1);
    applyStimulus("to5", 1'b0, 1'b1);
    applyStimulus("simul", 1'b1, 1'b1);
    applyStimulus("after_simul", 1'b0, 1'b1);

    // Saturation: MISS held for 20 edges, then INIT clears both.
    applyStimulus("sat_reset", 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus("sat_run", 1'b0, 1'b1);
    applyStimulus("sat_hold", 1'b0, 1'b0);
    applyStimulus("sat_clear", 1'b1, 1'b0);

    // Unknown strobe counts as no miss.
    for (int i = 0; i < 3; i++) applyStimulus("xguard", 1'b0, 1'bx);

    // Single pulse between idle edges for latency.
    applyStimulus("lat_idle", 1'b0, 1'b0);
    applyStimulus("lat_pulse", 1'b0, 1'b1);
    applyStimulus("lat_after", 1'b0, 1'b0);

    // Random traffic with occasional INIT and miss bursts.
    for (int i = 0; i < 400; i++) begin
      logic initVal;
      logic missVal;
      initVal = ($urandom_range(0, 59) == 0);
      missVal = ($urandom_range(0, 3) != 0);
      applyStimulus("random", initVal, missVal);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
